motor_move_sequencer: RTL and testbench
=======================================

Name: motor_move_sequencer

Overview:
Command sequencer in front of motorCtrl. Buffers absolute target positions with per-move velocity limits in a small FIFO. For each target it computes signed delta and direction from cur_position, splits moves larger than 16 bits into segments, and issues one-cycle newPosSignal pulses. It waits for arrival or timeout, then dwells before starting the next move.

Parameters:
FIFO_DEPTH, 4, command FIFO entries (power of 2, 2..16)
SETTLE_CYCLES, 50000, dwell after arrival before next segment/command (1 ms at 50 MHz)
TIMEOUT_CYCLES, 250000000, max cycles in WAIT per segment (5 s)
VEL_DIV_MIN, 24'h000115, lower clamp on velocity divider (max speed)

Ports:
CLK_50MHZ  in  1  system clock
RST_N  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept; high = !full && !abort
cmd_target  in  32  absolute target position, two's complement
cmd_velocity_div  in  24  requested velocity divider
abort  in  1  flush FIFO, drop current move, clear error
cur_position  in  32  motorCtrl position feedback
velocityMax_div  out  24  to motorCtrl
deltaPos  out  16  segment magnitude to motorCtrl
dir  out  1  1 = positive (position increments), 0 = negative
newPosSignal  out  1  one-cycle start pulse to motorCtrl
busy  out  1  high in any state except IDLE
fifo_count  out  5  entries held, 0..FIFO_DEPTH
move_done  out  1  one-cycle pulse when a command fully completes (including zero-length)
timeout_err  out  1  sticky; set on WAIT timeout

Behaviour:
- Reset (async, RST_N=0): state=IDLE, FIFO empty, all outputs 0 except cmd_ready=1 after release. velocityMax_div resets to 24'h01E848.
- FIFO write: occurs on an edge with cmd_valid && cmd_ready. cmd_ready ignores a same-cycle pop. With a full FIFO the push is refused even if a pop occurs that cycle.
- IDLE: if fifo_count>0 and !timeout_err, go to POP.
- POP: latch target and vel = max(cmd_velocity_div, VEL_DIV_MIN) from the FIFO head; decrement count; go to CALC.
- CALC: delta = target - cur_position, 32-bit wrap arithmetic, signed.
  - delta==0: pulse move_done and go to IDLE.
  - Otherwise: dir = (delta>0); mag = |delta| clamped to 65535; seg_end = cur_position ± mag (wrap arithmetic); go to ISSUE.
- ISSUE: drive deltaPos=mag, dir, velocityMax_div=vel; newPosSignal=1 for exactly this cycle; clear timeout counter; go to WAIT.
  - deltaPos, dir and velocityMax_div are held stable until the next ISSUE.
- Latency from idle with an empty FIFO: accept on edge N, POP in cycle N+1, CALC in N+2, newPosSignal high in cycle N+3.
- WAIT:
  - cur_position == seg_end: go to SETTLE and load the dwell counter with SETTLE_CYCLES-1.
  - Else, timeout counter reaches TIMEOUT_CYCLES-1: set timeout_err, flush FIFO, go to IDLE (no move_done).
- SETTLE: count down to 0.
  - At 0, if cur_position==target, pulse move_done and go to IDLE; the next command is popped the following cycle.
  - Otherwise go to CALC, which issues the next segment of the same command.
- abort: highest priority. Next state is IDLE, FIFO is flushed, timeout_err cleared, no pulses that cycle, cmd_ready=0 while abort is high.
  - An already-started motorCtrl profile is not stopped; abort only stops further issuing.
- timeout_err=1 blocks popping; pushes are still accepted. Only abort or reset clears it.
- Simultaneous push with POP: both are honoured; count stays unchanged.
- move_done and newPosSignal are never high in the same cycle.

Test Plan:
- Reset mid-WAIT: RST_N low for 1 cycle -> outputs 0, fifo_count=0, busy=0, no newPosSignal after release.
- Single move, cur_position=0, target=1000, vel=24'h00F424:
  - newPosSignal 3 cycles after accept, with deltaPos=1000, dir=1, velocityMax_div=24'h00F424.
  - Model drives cur_position to 1000 -> move_done exactly SETTLE_CYCLES+1 cycles later.
- Long negative move: cur_position=0, target=-150000 -> three segments, deltaPos 65535, 65535, 18930, all dir=0; a single move_done at the end.
- Clamp and zero-length:
  - vel=24'h000010 -> velocityMax_div=24'h000115.
  - target equal to cur_position -> move_done, no newPosSignal.
- FIFO full: push 5 commands while WAIT is blocked -> 5th refused (cmd_ready=0), fifo_count=4; all four execute in order.
- Timeout (TIMEOUT_CYCLES=100): freeze cur_position -> timeout_err=1 at cycle 100 of WAIT, FIFO flushed, no further pulses; abort clears timeout_err.

Source files
------------

// File: rtl/motor_move_sequencer.sv
// motor_move_sequencer: buffers absolute move commands and feeds motorCtrl one <=16-bit segment at a time,
// waiting for arrival (or timeout) and a settle dwell between segments.
module motor_move_sequencer #(
    parameter int          FIFO_DEPTH     = 4,
    parameter int          SETTLE_CYCLES  = 50000,
    parameter int          TIMEOUT_CYCLES = 250000000,
    parameter logic [23:0] VEL_DIV_MIN    = 24'h000115
) (
    input  logic        CLK_50MHZ,
    input  logic        RST_N,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_target,
    input  logic [23:0] cmd_velocity_div,
    input  logic        abort,
    input  logic [31:0] cur_position,
    output logic [23:0] velocityMax_div,
    output logic [15:0] deltaPos,
    output logic        dir,
    output logic        newPosSignal,
    output logic        busy,
    output logic [4:0]  fifo_count,
    output logic        move_done,
    output logic        timeout_err
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [2:0] {IDLE, POP, CALC, ISSUE, WAIT, SETTLE} state_t;

    state_t        state, state_nx;
    logic [31:0]   fifo_tgt [FIFO_DEPTH];
    logic [23:0]   fifo_vel [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, wr_idx;
    logic [31:0]   target, seg_end, cnt, delta, delta_abs;
    logic [23:0]   vel;
    logic [15:0]   mag;
    logic          push, pop, arrived, expired, flush, at_target;

    assign delta     = target - cur_position;
    assign delta_abs = delta[31] ? -delta : delta;
    assign mag       = |delta_abs[31:16] ? 16'hFFFF : delta_abs[15:0];
    assign arrived   = cur_position == seg_end;
    assign at_target = cur_position == target;
    assign expired   = state == WAIT && !arrived && cnt == 32'(TIMEOUT_CYCLES - 1);
    assign cmd_ready = fifo_count != 5'(FIFO_DEPTH) && !abort;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = state == POP && !abort;
    assign flush     = abort || expired;
    // a push landing on the timeout flush becomes the sole entry
    assign wr_idx    = flush ? '0 : wr_ptr;

    always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (fifo_count != '0 && !timeout_err) ? POP : IDLE;
            POP:     state_nx = CALC;
            CALC:    state_nx = (delta == '0) ? IDLE : ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = arrived ? SETTLE : expired ? IDLE : WAIT;
            SETTLE:  state_nx = (cnt != '0) ? SETTLE : at_target ? IDLE : CALC;
            default: state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    always_comb begin
        busy         = state != IDLE;
        newPosSignal = state == ISSUE && !abort;
        move_done    = !abort && ((state == CALC && delta == '0) || (state == SETTLE && cnt == '0 && at_target));
    end

    always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (flush) begin
            wr_ptr     <= AW'(push);
            rd_ptr     <= '0;
            fifo_count <= 5'(push);
        end else begin
            wr_ptr     <= wr_ptr + AW'(push);
            rd_ptr     <= rd_ptr + AW'(pop);
            fifo_count <= fifo_count + 5'(push) - 5'(pop);
        end
    end

    always_ff @(posedge CLK_50MHZ) begin
        if (push) begin
            fifo_tgt[wr_idx] <= cmd_target;
            fifo_vel[wr_idx] <= cmd_velocity_div;
        end
    end

    always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
        if (!RST_N) begin
            target          <= '0;
            vel             <= '0;
            seg_end         <= '0;
            cnt             <= '0;
            deltaPos        <= '0;
            dir             <= 1'b0;
            velocityMax_div <= 24'h01E848;
            timeout_err     <= 1'b0;
        end else begin
            if (pop) begin
                target <= fifo_tgt[rd_ptr];
                vel    <= (fifo_vel[rd_ptr] < VEL_DIV_MIN) ? VEL_DIV_MIN : fifo_vel[rd_ptr];
            end
            if (state == CALC && state_nx == ISSUE) begin
                deltaPos        <= mag;
                dir             <= !delta[31];
                velocityMax_div <= vel;
                seg_end         <= delta[31] ? cur_position - 32'(mag) : cur_position + 32'(mag);
            end
            cnt <= state == ISSUE ? '0 :
                   state == WAIT ? (arrived ? 32'(SETTLE_CYCLES - 1) : cnt + 1) :
                   (state == SETTLE && cnt != '0) ? cnt - 1 : cnt;
            timeout_err <= abort ? 1'b0 : expired ? 1'b1 : timeout_err;
        end
    end
endmodule

// File: tb/tb_motor_move_sequencer.sv
// tb_motor_move_sequencer: directed and randomized moves against a segment-list model and a simple motor model.
module tb_motor_move_sequencer;
    localparam int S = 20;
    localparam int T = 100;

    logic        CLK_50MHZ = 0, RST_N = 0, cmd_valid = 0, abort = 0;
    logic [31:0] cmd_target = 0, cur_position = 0;
    logic [23:0] cmd_velocity_div = 0;
    logic        cmd_ready, dir, newPosSignal, busy, move_done, timeout_err;
    logic [23:0] velocityMax_div;
    logic [15:0] deltaPos;
    logic [4:0]  fifo_count;

    motor_move_sequencer #(.FIFO_DEPTH(4), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T), .VEL_DIV_MIN(24'h000115)) dut (
        .CLK_50MHZ(CLK_50MHZ), .RST_N(RST_N), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_target(cmd_target), .cmd_velocity_div(cmd_velocity_div), .abort(abort),
        .cur_position(cur_position), .velocityMax_div(velocityMax_div), .deltaPos(deltaPos),
        .dir(dir), .newPosSignal(newPosSignal), .busy(busy), .fifo_count(fifo_count),
        .move_done(move_done), .timeout_err(timeout_err)
    );

    always #5 CLK_50MHZ = ~CLK_50MHZ;

    typedef struct {
        bit          done;
        logic [15:0] d;
        bit          dr;
        logic [23:0] v;
        logic [31:0] goal;
    } ev_t;

    ev_t         ev[$];
    int          checks = 0, passed = 0, cyc = 0, acc_cyc = 0, last_issue_cyc = 0, last_done_cyc = 0;
    int          n_issue = 0, n_done = 0;
    logic [31:0] model_pos = 0, goal = 0;
    bit          freeze = 0, instant = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // expected pulse sequence for one command, starting where the previous command ends
    task automatic model_add(input logic [31:0] t, input logic [23:0] v);
        logic [31:0] pos, rem;
        int unsigned m;
        ev_t e;
        pos = model_pos;
        e.v = (v < 24'h000115) ? 24'h000115 : v;
        rem = t - pos;
        while (rem != 0) begin
            e.done = 0;
            e.dr   = $signed(rem) > 0;
            m      = e.dr ? rem : 32'd0 - rem;
            if (m > 65535) m = 65535;
            e.d    = m[15:0];
            pos    = e.dr ? pos + m : pos - m;
            e.goal = pos;
            ev.push_back(e);
            rem    = t - pos;
        end
        e.done = 1;
        e.d    = 0;
        e.dr   = 0;
        e.goal = pos;
        ev.push_back(e);
        model_pos = t;
    endtask

    task automatic tick();
        ev_t e;
        logic [31:0] diff, st;
        @(negedge CLK_50MHZ);
        cyc++;
        if (newPosSignal || move_done) begin
            check("pulse_overlap", 32'(newPosSignal & move_done), 0);
            if (ev.size() == 0) begin
                check("issue_unexpected", 32'(newPosSignal), 0);
                check("done_unexpected", 32'(move_done), 0);
            end else begin
                e = ev.pop_front();
                check("pulse_kind", 32'(move_done), 32'(e.done));
                if (newPosSignal && !e.done) begin
                    check("deltaPos", 32'(deltaPos), 32'(e.d));
                    check("dir", 32'(dir), 32'(e.dr));
                    check("velocityMax_div", 32'(velocityMax_div), 32'(e.v));
                    goal = e.goal;
                    last_issue_cyc = cyc;
                    n_issue++;
                    if (instant) cur_position = goal;
                end
                if (move_done) begin
                    last_done_cyc = cyc;
                    n_done++;
                end
            end
        end
        if (!freeze && cur_position != goal) begin
            diff = goal - cur_position;
            st   = $urandom_range(40000, 2000);
            if ($signed(diff) > 0) cur_position += (diff < st) ? diff : st;
            else cur_position -= ((32'd0 - diff) < st) ? (32'd0 - diff) : st;
        end
    endtask

    task automatic push(input logic [31:0] t, input logic [23:0] v, input bit model);
        int n = 0;
        cmd_valid = 1;
        cmd_target = t;
        cmd_velocity_div = v;
        while (!cmd_ready && n < 500) begin
            tick();
            n++;
        end
        if (!cmd_ready) check("push_ready", 32'(cmd_ready), 1);
        else if (model) model_add(t, v);
        tick();
        acc_cyc = cyc;
        cmd_valid = 0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((ev.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        check("drain_pending", 32'(ev.size()), 0);
        check("drain_busy", 32'(busy), 0);
    endtask

    task automatic wait_issue(input int budget);
        int n = 0, k = n_issue;
        while (n_issue == k && n < budget) begin
            tick();
            n++;
        end
        check("issue_seen", 32'(n_issue - k), 1);
    endtask

    initial begin
        int k, d, i;
        logic [31:0] off;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_fifo_count", 32'(fifo_count), 0);
        check("rst_newPos", 32'(newPosSignal), 0);
        check("rst_move_done", 32'(move_done), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        check("rst_deltaPos", 32'(deltaPos), 0);
        check("rst_dir", 32'(dir), 0);
        check("rst_vel", 32'(velocityMax_div), 32'h01E848);
        RST_N = 1;
        tick();
        check("rst_cmd_ready", 32'(cmd_ready), 1);

        instant = 1;
        push(32'd1000, 24'h00F424, 1);
        wait_issue(20);
        check("issue_latency", 32'(last_issue_cyc - acc_cyc), 3);
        wait_idle(200);
        check("done_latency", 32'(last_done_cyc - last_issue_cyc), S + 1);
        instant = 0;

        k = n_issue;
        d = n_done;
        push(32'd1000 - 32'd150000, 24'($urandom), 1);
        wait_idle(2000);
        check("long_segments", 32'(n_issue - k), 3);
        check("long_done", 32'(n_done - d), 1);

        push(model_pos + 32'd7, 24'h000010, 1);
        wait_idle(500);
        check("clamp_held", 32'(velocityMax_div), 32'h000115);

        k = n_issue;
        d = n_done;
        push(model_pos, 24'h001234, 1);
        wait_idle(50);
        check("zero_no_issue", 32'(n_issue - k), 0);
        check("zero_done", 32'(n_done - d), 1);

        freeze = 1;
        push(model_pos + 32'd30000, 24'h000400, 1);
        wait_issue(20);
        for (int j = 0; j < 4; j++) push(model_pos + 32'($urandom_range(70000)) - 32'd35000, 24'($urandom), 1);
        check("full_count", 32'(fifo_count), 4);
        check("full_ready", 32'(cmd_ready), 0);
        cmd_valid = 1;
        cmd_target = 32'h12345678;
        tick();
        cmd_valid = 0;
        check("full_refused", 32'(fifo_count), 4);
        freeze = 0;
        wait_idle(3000);

        freeze = 1;
        push(model_pos + 32'd50000, 24'h000800, 1);
        wait_issue(20);
        i = last_issue_cyc;
        push(32'd5, 24'h000200, 0);
        push(32'd9, 24'h000200, 0);
        while (cyc < i + T) tick();
        check("tmo_not_yet", 32'(timeout_err), 0);
        tick();
        check("tmo_err", 32'(timeout_err), 1);
        check("tmo_flushed", 32'(fifo_count), 0);
        check("tmo_idle", 32'(busy), 0);
        ev.delete();
        k = n_issue;
        repeat (20) tick();
        push(32'd77, 24'h000300, 0);
        repeat (5) tick();
        check("tmo_push_kept", 32'(fifo_count), 1);
        check("tmo_blocked", 32'(busy), 0);
        check("tmo_no_issue", 32'(n_issue - k), 0);
        abort = 1;
        #1;
        check("abort_ready", 32'(cmd_ready), 0);
        tick();
        abort = 0;
        check("abort_clr_err", 32'(timeout_err), 0);
        check("abort_flush", 32'(fifo_count), 0);
        check("abort_idle", 32'(busy), 0);
        freeze = 0;
        goal = cur_position;
        model_pos = cur_position;

        freeze = 1;
        push(model_pos + 32'd20000, 24'h000500, 1);
        wait_issue(20);
        repeat (3) tick();
        RST_N = 0;
        ev.delete();
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_count", 32'(fifo_count), 0);
        check("mid_rst_newPos", 32'(newPosSignal), 0);
        check("mid_rst_deltaPos", 32'(deltaPos), 0);
        check("mid_rst_vel", 32'(velocityMax_div), 32'h01E848);
        tick();
        RST_N = 1;
        freeze = 0;
        goal = cur_position;
        model_pos = cur_position;
        k = n_issue;
        repeat (30) tick();
        check("post_rst_no_issue", 32'(n_issue - k), 0);
        check("post_rst_idle", 32'(busy), 0);
        check("post_rst_ready", 32'(cmd_ready), 1);

        for (int j = 0; j < 30; j++) begin
            if ($urandom_range(2) == 0) repeat ($urandom_range(30)) tick();
            case ($urandom_range(3))
                0:       off = 0;
                1:       off = $urandom_range(5000, 1);
                2:       off = $urandom_range(200000, 60000);
                default: off = 32'd65535 + 32'($urandom_range(1));
            endcase
            if ($urandom_range(1) == 1) off = 32'd0 - off;
            push(model_pos + off, $urandom_range(1) ? 24'($urandom_range(24'h000200)) : 24'($urandom), 1);
        end
        wait_idle(20000);
        check("final_count", 32'(fifo_count), 0);
        check("final_err", 32'(timeout_err), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
